// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and constants for the MAC sequencer
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_4X4 = 1'b0;
  localparam logic MODE_8X8 = 1'b1;

  localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/mac_seq_ctrl_mult.sv
// rtl/mac_seq_ctrl_mult.sv - precision-scalable multiplier: one 8x8 or two 4x4 products
module Multiplier_8x8 (
  input  logic [7:0]  In_1,
  input  logic [7:0]  In_2,
  input  logic        Sign,
  input  logic        Mode,
  output logic [15:0] Result
);

  logic signed [8:0]  a_wide, b_wide;
  logic signed [4:0]  a_lo, b_lo, a_hi, b_hi;
  logic signed [15:0] prod_full;
  logic signed [7:0]  prod_lo, prod_hi;

  // One extra bit per operand lets a single signed multiply cover both signednesses.
  always_comb begin
    a_wide    = {Sign & In_1[7], In_1};
    b_wide    = {Sign & In_2[7], In_2};
    a_lo      = {Sign & In_1[3], In_1[3:0]};
    b_lo      = {Sign & In_2[3], In_2[3:0]};
    a_hi      = {Sign & In_1[7], In_1[7:4]};
    b_hi      = {Sign & In_2[7], In_2[7:4]};
    prod_full = 16'(a_wide) * 16'(b_wide);
    prod_lo   = 8'(a_lo) * 8'(b_lo);
    prod_hi   = 8'(a_hi) * 8'(b_hi);
    Result    = Mode ? prod_full : {prod_hi, prod_lo};
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - dot-product MAC sequencer streaming operand beats through Multiplier_8x8
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             mode,
  input  logic             sign,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, beat_cnt;
  logic             mode_q, sign_q;
  logic [1:0]       drain_cnt;

  logic [7:0]       op_a, op_b;
  logic             op_valid;
  logic [15:0]      mul_res, prod_q;
  logic             prod_valid;

  logic [ACC_W-1:0] acc_q, term, full_ext, lo_ext, hi_ext;
  logic [ACC_W:0]   sum_u;
  logic             ovf_q, ovf_add;

  logic job_start, accept, last_beat;

  assign job_start = (state == IDLE) && start;
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == len_q - LEN_W'(1));

  Multiplier_8x8 u_mult (
    .In_1   (op_a),
    .In_2   (op_b),
    .Sign   (sign_q),
    .Mode   (mode_q),
    .Result (mul_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (vec_len == '0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    full_ext = sign_q ? {{(ACC_W-16){prod_q[15]}}, prod_q}
                      : {{(ACC_W-16){1'b0}}, prod_q};
    lo_ext   = sign_q ? {{(ACC_W-8){prod_q[7]}}, prod_q[7:0]}
                      : {{(ACC_W-8){1'b0}}, prod_q[7:0]};
    hi_ext   = sign_q ? {{(ACC_W-8){prod_q[15]}}, prod_q[15:8]}
                      : {{(ACC_W-8){1'b0}}, prod_q[15:8]};
    term     = (mode_q == MODE_8X8) ? full_ext : (hi_ext + lo_ext);
    sum_u    = {1'b0, acc_q} + {1'b0, term};
    // Signed overflow: operands agree in sign but the wrapped sum does not.
    ovf_add  = sign_q ? ((acc_q[ACC_W-1] == term[ACC_W-1]) &&
                         (sum_u[ACC_W-1] != acc_q[ACC_W-1]))
                      : sum_u[ACC_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      beat_cnt   <= '0;
      mode_q     <= MODE_8X8;
      sign_q     <= 1'b0;
      drain_cnt  <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_valid   <= 1'b0;
      prod_q     <= '0;
      prod_valid <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      op_valid   <= accept;
      prod_valid <= op_valid;
      drain_cnt  <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (accept) begin
        op_a     <= in_a;
        op_b     <= in_b;
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if (op_valid) prod_q <= mul_res;
      if (prod_valid) begin
        acc_q <= sum_u[ACC_W-1:0];
        ovf_q <= ovf_q | ovf_add;
      end
      if (job_start) begin
        len_q    <= vec_len;
        mode_q   <= mode;
        sign_q   <= sign;
        beat_cnt <= '0;
        acc_q    <= '0;
        ovf_q    <= 1'b0;
      end
    end
  end

  assign acc_out = acc_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer that streams operand pairs through the shared precision-scalable `Multiplier_8x8` and accumulates the products into one dot-product result. It accepts a job through `start`, consumes `vec_len` operand beats over a valid/ready handshake, and presents the accumulated sum over a second valid/ready handshake. It is the per-lane MAC engine of the NPU, sitting between the operand buffer and the result writeback.

## Interface
- `ACC_W`, 24: accumulator and result width; must be ≥17.
- `LEN_W`, 8: width of the vector-length field.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only in IDLE.
- `vec_len` in LEN_W: number of beats in the job; latched on `start`.
- `mode` in 1: 1 = one 8x8 product per beat; 0 = two 4x4 products per beat (nibble lanes). Latched on `start`.
- `sign` in 1: 1 = two's-complement operands; latched on `start`.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: controller accepts a beat.
- `in_a`, `in_b` in 8: operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `acc_out` out ACC_W: accumulated result.
- `ovf` out 1: sticky overflow for the current job; valid with `out_valid`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
  - IDLE→RUN on `start` when `vec_len`≠0. This clears the accumulator, `ovf` and the beat counter.
  - IDLE→DONE on `start` when `vec_len`=0. `acc_out` is 0 and `ovf` is 0.
  - RUN→DRAIN on the edge that accepts the final beat.
  - DRAIN lasts exactly 2 cycles, then moves to DONE.
  - DONE→IDLE on `out_valid && out_ready`.
- `in_ready` is high only in RUN. A beat transfers on `in_valid && in_ready`.
- `start` is ignored outside IDLE.
- Pipeline:
  - On accept, the operand register loads `in_a`/`in_b`, with a valid bit.
  - The registered operands, latched `sign` and latched `mode` drive `Multiplier_8x8` combinationally.
  - The product register loads the 16-bit result next cycle, with a valid bit.
  - The accumulator adds the product term the cycle after that, only when its valid bit is set.
- Product term:
  - In mode 1 the term is `Result[15:0]`, sign-extended to ACC_W when `sign`=1 and zero-extended otherwise.
  - In mode 0 the term is `Result[15:8]` + `Result[7:0]`, each lane extended from 8 bits in the same way.
  - Lane mapping in mode 0: the low lane is `in_a[3:0]`×`in_b[3:0]`; the high lane is `in_a[7:4]`×`in_b[7:4]`.
- Accumulation wraps modulo 2^ACC_W.
  - `ovf` is set when `sign`=0 and the add produces a carry out.
  - `ovf` is set when `sign`=1 and the add overflows in two's complement.
  - Once set, `ovf` stays high until the next `start`.
- Stalls: `in_valid` low in RUN inserts bubbles. The bubbles carry valid=0 and do not accumulate.
- Reset mid-job aborts the job. All state, registers and valid bits clear immediately.

## Timing
- Reset values:
  - `in_ready`, `out_valid`, `busy` and `ovf` are 0.
  - `acc_out` is 0.
  - FSM is in IDLE.
- `start` sampled at edge s:
  - `busy` and `in_ready` are high from s.
  - For `vec_len`=0, `out_valid` is high from s.
- Final beat accepted at edge t: `acc_out` is final and `out_valid` rises at edge t+2.
- Throughput: 1 beat/cycle sustained. No new job can start before the result is consumed.
- `acc_out` and `ovf` hold stable while `out_valid` is high and `out_ready` is low.
- Back-to-back jobs: `start` is sampled no earlier than the edge after the result handshake.

## Structure
- Package `mac_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - mode constants `MODE_4X4`=0 and `MODE_8X8`=1;
  - the DRAIN length constant (2).
- Single sub-module: one `Multiplier_8x8` instance, port mapping `In_1`=opA, `In_2`=opB, `Sign`, `Mode`, `Result`.
- The beat counter, accumulator with overflow logic, and FSM stay in `mac_seq_ctrl`.

## Test plan
- **Mode 1, unsigned, length 3.** `vec_len`=3 with beats (255,255), (1,2), (10,10). Expect `acc_out`=65127 and `ovf`=0. `out_valid` rises 2 cycles after the last accept.
- **Mode 1, signed, length 2.** `sign`=1 with beats (8'hFF,8'h02) and (8'h80,8'h80). Expect `acc_out`=16382, `ovf`=0.
- **Mode 0, unsigned, length 1.** Beat (8'h34,8'h56). Expect `acc_out`=39 (4·6+3·5).
- **Zero length and back-pressure.**
  - `vec_len`=0: `out_valid` is high after the `start` edge with `acc_out`=0.
  - Hold `out_ready`=0 for 5 cycles: result stays stable, `in_ready`=0, and a second `start` is ignored.
- **Overflow and stalls.** `ACC_W`=17, mode 1, unsigned, 3×(255,255), with `in_valid` toggled between beats. Expect `acc_out`=64003 and `ovf`=1.
- **Reset mid-job.** Assert `rst_n`=0 during RUN after 2 beats. Outputs go to reset values immediately. A new job of (3,4) then yields 12.
